// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: decoder controls and mem handshake in, strobes and status out.
// master = sequencer side, slave = datapath/memory side.
interface multicycle_ctrl_if;
   logic        RegWE;
   logic        MemWE;
   logic [1:0]  WBSel;
   logic        halt_req;
   logic        mem_ready;
   logic        mem_req;
   logic        mem_we;
   logic        addr_sel;
   logic        ir_we;
   logic        rf_we;
   logic        pc_we;
   logic [2:0]  state;
   logic        halted;
   logic        err;
   logic [31:0] cycle_cnt;
   logic [31:0] instret;

   modport master (
      input  RegWE, MemWE, WBSel, halt_req, mem_ready,
      output mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we,
             state, halted, err, cycle_cnt, instret
   );

   modport slave (
      output RegWE, MemWE, WBSel, halt_req, mem_ready,
      input  mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we,
             state, halted, err, cycle_cnt, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// F/D/E/M/WB sequencer over one shared memory port; 3-5 cycles per instruction plus memory waits.
// Stalls in FETCH/MEM until mem_ready; MEM_TIMEOUT unanswered request cycles force a sticky error halt.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   multicycle_ctrl_if.master bus
);
   localparam int WW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t        state_q;
   logic [WW-1:0] wait_cnt;
   logic [31:0]   cycle_q;
   logic [31:0]   instret_q;
   logic          err_q;

   logic   is_load;
   logic   is_store;
   logic   mem_req_c;
   logic   mem_we_c;
   logic   addr_sel_c;
   logic   ir_we_c;
   logic   rf_we_c;
   logic   retire;
   logic   timeout;
   state_t retire_next;

   // Strobes follow the current state; rst blanks all of them in the same cycle.
   always_comb begin
      is_load     = (bus.WBSel == 2'b01) && bus.RegWE;
      is_store    = bus.MemWE;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      addr_sel_c  = 1'b0;
      ir_we_c     = 1'b0;
      rf_we_c     = 1'b0;
      retire      = 1'b0;
      retire_next = bus.halt_req ? S_HALT : S_FETCH;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req_c = 1'b1;
               ir_we_c   = bus.mem_ready;
            end
            S_EXEC: begin
               retire = !is_load && !is_store && !bus.RegWE;
            end
            S_MEM: begin
               mem_req_c  = 1'b1;
               addr_sel_c = 1'b1;
               mem_we_c   = bus.MemWE;
               retire     = bus.mem_ready && !is_load;
            end
            S_WB: begin
               rf_we_c = bus.RegWE;
               retire  = 1'b1;
            end
            default: ;
         endcase
      end
      timeout = mem_req_c && !bus.mem_ready && (wait_cnt == WAIT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         wait_cnt  <= '0;
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         if (state_q != S_HALT) cycle_q <= cycle_q + 32'd1;
         if (retire) instret_q <= instret_q + 32'd1;

         // Non-waiting states hold the counter at zero, so it is clear on entry to FETCH/MEM.
         if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready)
            wait_cnt <= wait_cnt + WW'(1);
         else
            wait_cnt <= '0;

         case (state_q)
            S_FETCH: begin
               if (bus.mem_ready) begin
                  state_q <= S_DECODE;
               end else if (timeout) begin
                  state_q <= S_HALT;
                  err_q   <= 1'b1;
               end
            end
            S_DECODE: state_q <= S_EXEC;
            S_EXEC: begin
               if (is_load || is_store) state_q <= S_MEM;
               else if (bus.RegWE)      state_q <= S_WB;
               else                     state_q <= retire_next;
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  state_q <= is_load ? S_WB : retire_next;
               end else if (timeout) begin
                  state_q <= S_HALT;
                  err_q   <= 1'b1;
               end
            end
            S_WB:    state_q <= retire_next;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.mem_req   = mem_req_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.addr_sel  = addr_sel_c;
   assign bus.ir_we     = ir_we_c;
   assign bus.rf_we     = rf_we_c;
   assign bus.pc_we     = retire;
   assign bus.state     = state_q;
   assign bus.halted    = (state_q == S_HALT);
   assign bus.err       = err_q;
   assign bus.cycle_cnt = cycle_q;
   assign bus.instret   = instret_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vectors for multicycle_ctrl (MEM_TIMEOUT=4): instruction mixes, waits, halt, reset, timeouts.
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // strb bit order: mem_req mem_we addr_sel ir_we rf_we pc_we halted err
   typedef struct {
      logic        rst;
      logic        rwe;
      logic        mwe;
      logic [1:0]  wbs;
      logic        hr;
      logic        rdy;
      logic [2:0]  st;
      logic [7:0]  strb;
      logic [31:0] cyc;
      logic [31:0] ret;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   vec_t tbl[$];

   function automatic vec_t v(logic r, logic rwe, logic mwe, logic [1:0] wbs, logic hr, logic rdy,
                              logic [2:0] st, logic [7:0] strb, int cyc, int ret);
      vec_t x;
      x.rst = r;  x.rwe = rwe; x.mwe = mwe; x.wbs = wbs; x.hr = hr; x.rdy = rdy;
      x.st = st;  x.strb = strb; x.cyc = 32'(cyc); x.ret = 32'(ret);
      return x;
   endfunction

   // Drive one cycle's inputs after the falling edge, compare before the next rising edge.
   task automatic apply(input vec_t e, input string name);
      logic [2:0]  a_st;
      logic [7:0]  a_strb;
      @(negedge clk);
      rst          = e.rst;
      bus.RegWE    = e.rwe;
      bus.MemWE    = e.mwe;
      bus.WBSel    = e.wbs;
      bus.halt_req = e.hr;
      bus.mem_ready = e.rdy;
      #2;
      a_st   = bus.state;
      a_strb = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we,
                bus.rf_we, bus.pc_we, bus.halted, bus.err};
      n_cmp++;
      if (a_st !== e.st || a_strb !== e.strb || bus.cycle_cnt !== e.cyc || bus.instret !== e.ret) begin
         n_err++;
         $display("FAIL %s: got st=%0d strb=%b cyc=%0d ret=%0d, want st=%0d strb=%b cyc=%0d ret=%0d",
                  name, a_st, a_strb, bus.cycle_cnt, bus.instret, e.st, e.strb, e.cyc, e.ret);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.RegWE = 1'b0; bus.MemWE = 1'b0; bus.WBSel = 2'b00;
      bus.halt_req = 1'b0; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      //                 rst rwe mwe wbs   hr rdy  st  strb         cyc ret
      tbl.push_back(v(1, 1, 0, 2'b00, 0, 1, 0, 8'b0000_0000, 0, 0));  // reset state, strobes blanked
      // ADD, zero wait
      tbl.push_back(v(0, 1, 0, 2'b00, 0, 1, 0, 8'b1001_0000, 0, 0));
      tbl.push_back(v(0, 1, 0, 2'b00, 0, 1, 1, 8'b0000_0000, 1, 0));
      tbl.push_back(v(0, 1, 0, 2'b00, 0, 1, 2, 8'b0000_0000, 2, 0));
      tbl.push_back(v(0, 1, 0, 2'b00, 0, 1, 4, 8'b0000_1100, 3, 0));
      // LW, two MEM wait cycles
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 1, 0, 8'b1001_0000, 4, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 1, 1, 8'b0000_0000, 5, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 1, 2, 8'b0000_0000, 6, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 0, 3, 8'b1010_0000, 7, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 0, 3, 8'b1010_0000, 8, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 1, 3, 8'b1010_0000, 9, 1));
      tbl.push_back(v(0, 1, 0, 2'b01, 0, 1, 4, 8'b0000_1100, 10, 1));
      // SW, zero wait: retires in MEM
      tbl.push_back(v(0, 0, 1, 2'b00, 0, 1, 0, 8'b1001_0000, 11, 2));
      tbl.push_back(v(0, 0, 1, 2'b00, 0, 1, 1, 8'b0000_0000, 12, 2));
      tbl.push_back(v(0, 0, 1, 2'b00, 0, 1, 2, 8'b0000_0000, 13, 2));
      tbl.push_back(v(0, 0, 1, 2'b00, 0, 1, 3, 8'b1110_0100, 14, 2));
      // branch with no write: retires in EXEC
      tbl.push_back(v(0, 0, 0, 2'b00, 0, 1, 0, 8'b1001_0000, 15, 3));
      tbl.push_back(v(0, 0, 0, 2'b00, 0, 1, 1, 8'b0000_0000, 16, 3));
      tbl.push_back(v(0, 0, 0, 2'b00, 0, 1, 2, 8'b0000_0100, 17, 3));
      // ADD with halt_req held; fetch answered in the 4th (last allowed) request cycle
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 0, 0, 8'b1000_0000, 18, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 0, 0, 8'b1000_0000, 19, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 0, 0, 8'b1000_0000, 20, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 1, 0, 8'b1001_0000, 21, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 1, 1, 8'b0000_0000, 22, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 1, 2, 8'b0000_0000, 23, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 1, 4, 8'b0000_1100, 24, 4));
      tbl.push_back(v(0, 1, 0, 2'b00, 1, 1, 5, 8'b0000_0010, 25, 5));
      tbl.push_back(v(0, 1, 1, 2'b01, 0, 1, 5, 8'b0000_0010, 25, 5));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("tbl%0d", i));

      // Leave HALT by reset, then reset in the middle of a store's MEM wait
      apply(v(1, 0, 1, 2'b00, 0, 1, 5, 8'b0000_0010, 25, 5), "rst_in_halt");
      apply(v(0, 0, 1, 2'b00, 0, 1, 0, 8'b1001_0000, 0, 0), "sw_fetch");
      apply(v(0, 0, 1, 2'b00, 0, 1, 1, 8'b0000_0000, 1, 0), "sw_decode");
      apply(v(0, 0, 1, 2'b00, 0, 1, 2, 8'b0000_0000, 2, 0), "sw_exec");
      apply(v(0, 0, 1, 2'b00, 0, 0, 3, 8'b1110_0000, 3, 0), "sw_mem_wait0");
      apply(v(0, 0, 1, 2'b00, 0, 0, 3, 8'b1110_0000, 4, 0), "sw_mem_wait1");
      apply(v(1, 0, 1, 2'b00, 0, 1, 3, 8'b0000_0000, 5, 0), "sw_mem_rst");
      apply(v(0, 1, 0, 2'b00, 0, 1, 0, 8'b1001_0000, 0, 0), "add2_fetch");
      apply(v(0, 1, 0, 2'b00, 0, 1, 1, 8'b0000_0000, 1, 0), "add2_decode");
      apply(v(0, 1, 0, 2'b00, 0, 1, 2, 8'b0000_0000, 2, 0), "add2_exec");
      apply(v(0, 1, 0, 2'b00, 0, 1, 4, 8'b0000_1100, 3, 0), "add2_wb");
      apply(v(0, 1, 0, 2'b00, 0, 0, 0, 8'b1000_0000, 4, 1), "add2_done");

      // FETCH timeout: 4 unanswered requests, then frozen error halt
      apply(v(1, 1, 0, 2'b00, 0, 0, 0, 8'b0000_0000, 5, 1), "to_rst");
      for (int i = 0; i < 4; i++)
         apply(v(0, 1, 0, 2'b00, 0, 0, 0, 8'b1000_0000, i, 0), $sformatf("to_fetch%0d", i));
      for (int i = 0; i < 20; i++)
         apply(v(0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'b1,
                 5, 8'b0000_0011, 4, 0), $sformatf("to_halt%0d", i));

      // MEM timeout on a store: no write completes, no retire
      apply(v(1, 0, 1, 2'b00, 0, 1, 5, 8'b0000_0011, 4, 0), "mto_rst");
      apply(v(0, 0, 1, 2'b00, 0, 1, 0, 8'b1001_0000, 0, 0), "mto_fetch");
      apply(v(0, 0, 1, 2'b00, 0, 1, 1, 8'b0000_0000, 1, 0), "mto_decode");
      apply(v(0, 0, 1, 2'b00, 0, 1, 2, 8'b0000_0000, 2, 0), "mto_exec");
      for (int i = 0; i < 4; i++)
         apply(v(0, 0, 1, 2'b00, 0, 0, 3, 8'b1110_0000, 3 + i, 0), $sformatf("mto_mem%0d", i));
      apply(v(0, 0, 1, 2'b00, 0, 1, 5, 8'b0000_0011, 7, 0), "mto_halt0");
      apply(v(0, 1, 0, 2'b01, 1, 1, 5, 8'b0000_0011, 7, 0), "mto_halt1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
